// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, checks alignment and range, performs a
// single-cycle memory access and returns an extended load result with handshake.
module load_store_unit #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_misaligned,
    output logic        resp_range_err,
    output logic        mem_wr,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        CAPTURE = 3'd2,
        RESP    = 3'd3
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  op_q, op_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        mis_q, mis_d;
    logic        rng_q, rng_d;
    logic        mem_wr_q, mem_wr_d;
    logic [2:0]  mem_op_q, mem_op_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]  size_m1;
    logic [32:0] last_byte;
    logic        req_mis;
    logic        req_rng;
    logic [31:0] load_ext;

    // Request checks; last byte is computed 33 bits wide so the top of the space cannot wrap.
    always_comb begin
        if (req_op[2]) begin
            size_m1 = 3'd3;
            req_mis = (req_addr[1:0] != 2'b00);
        end else if (req_op[1]) begin
            size_m1 = 3'd1;
            req_mis = req_addr[0];
        end else begin
            size_m1 = 3'd0;
            req_mis = 1'b0;
        end
        last_byte = {1'b0, req_addr} + 33'(size_m1);
        req_rng   = (last_byte >= 33'(DEPTH));
    end

    // Size/sign extension of the raw memory bytes.
    always_comb begin
        case (op_q)
            3'b000:  load_ext = {24'd0, mem_rdata[7:0]};
            3'b001:  load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b010:  load_ext = {16'd0, mem_rdata[15:0]};
            3'b011:  load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        op_d        = op_q;
        resp_data_d = resp_data_q;
        mis_d       = mis_q;
        rng_d       = rng_q;
        mem_wr_d    = 1'b0;
        mem_op_d    = mem_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d  = req_we;
                    op_d  = req_op;
                    mis_d = req_mis;
                    rng_d = req_rng;
                    if (req_mis || req_rng) begin
                        state_d     = RESP;
                        resp_data_d = 32'd0;
                    end else begin
                        state_d     = ACCESS;
                        mem_wr_d    = req_we;
                        mem_op_d    = req_op;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d     = RESP;
                    resp_data_d = 32'd0;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                state_d     = RESP;
                resp_data_d = load_ext;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered alongside the state they decode.
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            op_q         <= 3'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            mis_q        <= 1'b0;
            rng_q        <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_op_q     <= 3'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            op_q         <= op_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mis_q        <= mis_d;
            rng_q        <= rng_d;
            mem_wr_q     <= mem_wr_d;
            mem_op_q     <= mem_op_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_misaligned = mis_q;
    assign resp_range_err  = rng_q;
    assign mem_wr          = mem_wr_q;
    assign mem_op          = mem_op_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model behind it.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_misaligned;
    logic        resp_range_err;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] mem [0:2047];

    load_store_unit #(.DEPTH(2048)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_misaligned(resp_misaligned), .resp_range_err(resp_range_err),
        .mem_wr(mem_wr), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic int op_size(input logic [2:0] op);
        return op[2] ? 4 : (op[1] ? 2 : 1);
    endfunction

    // Memory model: writes on mem_wr, raw zero-filled read data one cycle after the address.
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = 32'd0;
        for (int i = 0; i < op_size(mem_op); i++) begin
            rd[8*i +: 8] = mem[11'(mem_addr + 32'(i))];
        end
        if (mem_wr) begin
            for (int i = 0; i < op_size(mem_op); i++) begin
                mem[11'(mem_addr + 32'(i))] = mem_wdata[8*i +: 8];
            end
        end
        mem_rdata <= rd;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_mis, input logic exp_rng, input int hold);
        int lat;
        int wr_cnt;
        @(negedge clk);
        check_eq({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_op = ~op; req_addr = ~addr; req_wdata = ~wdata;
        lat = 0;
        wr_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_wr) begin
                wr_cnt++;
                check_eq({tag, "/wr_addr"}, mem_addr, addr);
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "/wr_pulses"}, 32'(wr_cnt), (we && !exp_mis && !exp_rng) ? 32'd1 : 32'd0);
        check_eq({tag, "/data"}, resp_data, exp_data);
        check_eq({tag, "/mis"}, 32'(resp_misaligned), 32'(exp_mis));
        check_eq({tag, "/rng"}, 32'(resp_range_err), 32'(exp_rng));
        // Back-pressure: a competing request must not be taken while the response waits.
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_we = 1'b1; req_op = 3'b100; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;
            @(negedge clk);
            check_eq({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
            check_eq({tag, "/hold_data"}, resp_data, exp_data);
            check_eq({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
            check_eq({tag, "/hold_wr"}, 32'(mem_wr), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "/idle_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst/req_ready", 32'(req_ready), 32'd1);
        check_eq("rst/resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst/resp_data", resp_data, 32'd0);
        check_eq("rst/flags", {30'd0, resp_misaligned, resp_range_err}, 32'd0);
        check_eq("rst/mem_wr", 32'(mem_wr), 32'd0);
        check_eq("rst/mem_op", 32'(mem_op), 32'd0);
        check_eq("rst/mem_addr", mem_addr, 32'd0);
        check_eq("rst/mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_req("sw10", 1'b1, 3'b100, 32'h10, 32'hDEADBEEF, 2, 32'd0, 1'b0, 1'b0, 0);
        do_req("lw10", 1'b0, 3'b100, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 0);

        do_req("sb20", 1'b1, 3'b000, 32'h20, 32'h12345680, 2, 32'd0, 1'b0, 1'b0, 0);
        do_req("sh22", 1'b1, 3'b010, 32'h22, 32'hABCD8001, 2, 32'd0, 1'b0, 1'b0, 0);
        do_req("lb20", 1'b0, 3'b001, 32'h20, 32'h0, 3, 32'hFFFFFF80, 1'b0, 1'b0, 0);
        do_req("lbu20", 1'b0, 3'b000, 32'h20, 32'h0, 3, 32'h00000080, 1'b0, 1'b0, 0);
        do_req("lh22", 1'b0, 3'b011, 32'h22, 32'h0, 3, 32'hFFFF8001, 1'b0, 1'b0, 0);
        do_req("lhu22", 1'b0, 3'b010, 32'h22, 32'h0, 3, 32'h00008001, 1'b0, 1'b0, 0);
        do_req("lw20", 1'b0, 3'b101, 32'h20, 32'h0, 3, 32'h80010080, 1'b0, 1'b0, 0);

        do_req("lw13", 1'b0, 3'b100, 32'h13, 32'h0, 1, 32'd0, 1'b1, 1'b0, 0);
        do_req("sw13", 1'b1, 3'b100, 32'h13, 32'h11111111, 1, 32'd0, 1'b1, 1'b0, 0);
        do_req("lh7ff", 1'b0, 3'b011, 32'h7FF, 32'h0, 1, 32'd0, 1'b1, 1'b1, 0);
        do_req("sw7fc", 1'b1, 3'b100, 32'h7FC, 32'h12345678, 2, 32'd0, 1'b0, 1'b0, 0);
        do_req("lw7fc", 1'b0, 3'b100, 32'h7FC, 32'h0, 3, 32'h12345678, 1'b0, 1'b0, 0);
        do_req("sw800", 1'b1, 3'b100, 32'h800, 32'h22222222, 1, 32'd0, 1'b0, 1'b1, 0);
        check_eq("err/mem_addr_held", mem_addr, 32'h7FC);
        do_req("lw800", 1'b0, 3'b100, 32'h800, 32'h0, 1, 32'd0, 1'b0, 1'b1, 0);
        do_req("lbffff", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 1, 32'd0, 1'b0, 1'b1, 0);
        do_req("sb7ff", 1'b1, 3'b000, 32'h7FF, 32'h000000A5, 2, 32'd0, 1'b0, 1'b0, 0);
        do_req("lb7ff", 1'b0, 3'b001, 32'h7FF, 32'h0, 3, 32'hFFFFFFA5, 1'b0, 1'b0, 0);

        do_req("bp_lw10", 1'b0, 3'b100, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 5);
        do_req("bp_after", 1'b0, 3'b100, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 0);

        // Reset in the middle of a store access.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b100; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_eq("mid_rst/wr_before", 32'(mem_wr), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst/wr_drop", 32'(mem_wr), 32'd0);
        check_eq("mid_rst/ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst/valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst/valid", 32'(resp_valid), 32'd0);
            check_eq("post_rst/ready", 32'(req_ready), 32'd1);
        end
        do_req("lw40", 1'b0, 3'b100, 32'h40, 32'h0, 3, 32'd0, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning data memory size in bytes; legal byte addresses are 0..DEPTH-1.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, execute stage presents a request.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_op, input, 3, MemOP encoding: bit2 word, bit1 half, bit0 signed; 000 LBU, 001 LB, 010 LHU, 011 LH, 1xx LW/SW.
REQ-008 SHALL have ports req_addr (input, 32, byte address) and req_wdata (input, 32, store data, low bytes used).
REQ-009 SHALL have port resp_valid, output, 1, response available.
REQ-010 SHALL have port resp_ready, input, 1, writeback stage accepts the response.
REQ-011 SHALL have port resp_data, output, 32, extended load result; 0 for stores and errors.
REQ-012 SHALL have ports resp_misaligned and resp_range_err, outputs, 1 each, error flags valid with resp_valid.
REQ-013 SHALL have memory-side ports mem_wr (output, 1), mem_op (output, 3), mem_addr (output, 32), mem_wdata (output, 32) and mem_rdata (input, 32). Memory read data is raw bytes, zero-filled above the access size, and valid the cycle after the address is driven.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP; req_ready=1 only in IDLE.
REQ-015 SHALL accept a request on a posedge with req_valid&&req_ready, registering we/op/addr/wdata; inputs are ignored otherwise.
REQ-016 SHALL flag misaligned: half with addr[0]=1; word with addr[1:0]!=0; byte never.
REQ-017 SHALL flag range error when addr+size-1 >= DEPTH (size 1/2/4), computed without 32-bit wrap (addr 0xFFFFFFFF is out of range).
REQ-018 On an accepted request with any error: no memory access; go IDLE->RESP; set both flags as computed; resp_data=0.
REQ-019 On an accepted legal request: IDLE->ACCESS. In ACCESS, drive mem_addr/mem_op/mem_wdata from registers, with mem_wr=we for exactly this one cycle.
REQ-020 Store: ACCESS->RESP; resp_data=0. Load: ACCESS->CAPTURE.
REQ-021 In CAPTURE, sample mem_rdata and extend it, then go to RESP.
REQ-022 Extension rules: LB sign-extends bit7; LBU zero-extends byte; LH sign-extends bit15; LHU zero-extends half; LW passes 32 bits.
REQ-023 Outside ACCESS: mem_wr=0; mem_addr/mem_op/mem_wdata hold their last values.
REQ-024 In RESP: resp_valid=1, with resp_data and flags stable. Leave to IDLE on resp_ready=1; otherwise hold (back-pressure).
REQ-025 Latency from accept edge N: legal load resp_valid at N+3; legal store at N+2; error at N+1; next accept no earlier than the edge after the resp handshake.
REQ-026 mem_wr SHALL never be asserted for a request that has either error flag set.
REQ-027 Illegal FSM encodings SHALL recover to IDLE on the next clock.

Reset
REQ-028 While rst=1, immediately: state IDLE, req_ready=1, resp_valid=0, resp_data=0, flags 0, mem_wr=0, mem_op=0, mem_addr=0, mem_wdata=0.
REQ-029 Reset mid-operation (ACCESS/CAPTURE/RESP) SHALL abort the operation: no response, and mem_wr drops in the same cycle.

Verification
REQ-030 SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> mem_wr pulse 1 cycle in ACCESS; load resp_data=0xDEADBEEF at N+3.
REQ-031 Memory byte 0x80 at 0x20: LB -> 0xFFFFFF80; LBU -> 0x00000080. Half 0x8001: LH -> 0xFFFF8001; LHU -> 0x00008001.
REQ-032 LW addr 0x13 -> resp_misaligned=1 at N+1, mem_wr stays 0; LH addr 0x7FF (DEPTH 2048) -> misaligned=1, range_err=1; LW addr 0x7FC -> no error; LW addr 0x800 -> range_err=1.
REQ-033 Load completes with resp_ready=0 for 5 cycles -> resp_valid and resp_data held and req_ready=0 throughout; accept occurs only after resp_ready=1.
REQ-034 Assert rst during ACCESS of a store -> mem_wr falls immediately; after release the unit is in IDLE with req_ready=1 and no resp_valid.
